data_assembler_8to16: RTL and testbench
=======================================

# data_assembler_8to16

Byte-to-word assembler that packs a stream of 8-bit bytes back into 16-bit words. It is the receive-side counterpart of the 16-to-8 data converter, which emits the high byte `[15:8]` first and then the low byte `[7:0]`. The block sits between an 8-bit link and 16-bit consumers. It uses valid/ready handshakes on both sides and an alignment marker so a lost byte cannot leave the word phase permanently skewed.

## Interface
- `MSB_FIRST`, default 1: 1 = first byte of a pair goes to `dataout[15:8]`; 0 = first byte goes to `dataout[7:0]`.
- `clk`  input  1  — single clock; all logic on the rising edge.
- `rst`  input  1  — synchronous, active-high reset.
- `datain`  input  8  — byte payload, sampled on an accepted input handshake.
- `in_valid`  input  1  — `datain` and `align` are valid this cycle.
- `align`  input  1  — qualified by `in_valid`; marks this byte as the first byte of a word.
- `in_ready`  output  1  — the block accepts a byte this cycle.
- `dataout`  output  16  — assembled word, stable while `out_valid` is high.
- `out_valid`  output  1  — `dataout` holds a complete word.
- `out_ready`  input  1  — consumer takes the word this cycle.
- `pair_err`  output  1  — one-cycle pulse: a held first byte was discarded because of `align`.
- `phase`  output  1  — 1 = a first byte is held and the block is waiting for the second byte.

## Operation
- Accept: `acc = in_valid & in_ready`. Emit: `emit = out_valid & out_ready`.
- State is `phase` (0 EMPTY, 1 HALF), an 8-bit `hold` register, the `dataout` register and `out_valid`.
- Rule for `in_ready`:
  - `in_ready = (phase==0) | ~out_valid | out_ready`.
  - A first byte is always accepted, because it only fills `hold`.
  - A second byte needs the output register free, or being freed in the same cycle.
- EMPTY + `acc`:
  - `hold <= datain`, `phase -> HALF`.
  - `align` is ignored here.
- HALF + `acc` + `align=0`:
  - `dataout <= MSB_FIRST ? {hold, datain} : {datain, hold}`.
  - `out_valid <= 1`, `phase -> EMPTY`.
- HALF + `acc` + `align=1`:
  - The held byte is dropped and the new byte becomes the first byte: `hold <= datain`.
  - `phase` stays HALF, `pair_err` pulses for 1 cycle, and no word is produced.
- Output:
  - `out_valid` clears on `emit` unless a new word loads in the same cycle.
  - On simultaneous `emit` and word completion, the new word loads and `out_valid` stays 1. No bubble and no loss.
- Without `align`, consecutive accepted bytes pair strictly in order.
- No byte is duplicated. The only way a byte is dropped is the align discard.

## Timing
- Reset values (sync `rst`, which overrides all other inputs):
  - `phase=0`, `hold=0`, `dataout=16'h0000`, `out_valid=0`, `pair_err=0`.
  - `in_ready=1` in the cycle after reset, since it is derived combinationally.
- Latency: the word is visible, with `out_valid=1`, in the cycle after the second byte is accepted.
- Throughput: 1 word per 2 input cycles when `out_ready` is held high.
- Backpressure with output stalled and `phase=0`:
  - One more byte is accepted into `hold`.
  - `in_ready` then drops until `out_ready` is asserted.
- Contents of `dataout` change only on word completion. `dataout` is held unchanged while `out_valid & ~out_ready`.
- `pair_err` is registered: it is high in the cycle after the offending accept and for exactly that one cycle.
- `rst` mid-word: the held byte is discarded and the pending output word is discarded (`out_valid` goes to 0).
- `in_ready` and `out_valid` may depend combinationally on `out_ready` and on state only. There is no combinational path from `datain` to any output.

## Test plan
1. Reset and streaming:
   - Stimulus: reset, then bytes 12,34,56,78 with `in_valid=1` and `out_ready=1`.
   - Required response: words 16'h1234, then 16'h5678. Each is valid 1 cycle after its second byte; `pair_err` never asserts.
2. `MSB_FIRST=0`:
   - Stimulus: same bytes as scenario 1.
   - Required response: words 16'h3412, then 16'h7856.
3. Backpressure:
   - Stimulus: `out_ready=0`, send AA,BB,CC,DD.
   - Required response:
     - Word 16'hAABB is held stable and CC is accepted.
     - `in_ready` is 0 while DD is presented.
     - After `out_ready=1`, 16'hAABB emits and 16'hCCDD follows with no gap.
4. Realign:
   - Stimulus: send 11, then 22 with `align=1`, then 33.
   - Required response: `pair_err` pulses once; output is 16'h2233; 11 never appears in any word.
5. Reset mid-operation:
   - Stimulus: hold first byte 5A with `out_valid` pending, assert `rst` for 1 cycle, then send 01,02.
   - Required response: all outputs return to their reset values; the only word produced is 16'h0102.
6. Simultaneous emit and load:
   - Stimulus: with a word pending, present its second byte in the same cycle that `out_ready=1`.
   - Required response: `out_valid` stays 1 and the new word appears the next cycle.

Source files
------------

// File: rtl/data_assembler_8to16.sv
// Packs a stream of 8-bit bytes into 16-bit words, with an align marker that
// resynchronises the byte pairing after a lost byte.
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both high. Producers hold payload stable until it is taken; ready may depend
// combinationally on the opposite side's ready and on state, never on payload.
module data_assembler_8to16 #(
  parameter int unsigned MSB_FIRST = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  datain,
  input  logic        in_valid,
  input  logic        align,
  output logic        in_ready,
  output logic [15:0] dataout,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        pair_err,
  output logic        phase
);

  typedef enum logic {
    EMPTY = 1'b0,
    HALF  = 1'b1
  } state_t;

  state_t      state_q, state_d;
  logic [7:0]  hold_q, hold_d;
  logic [15:0] dataout_q, dataout_d;
  logic        out_valid_q, out_valid_d;
  logic        pair_err_q, pair_err_d;

  logic acc;
  logic emit;

  // A first byte only fills hold, so it never waits on the output side.
  assign in_ready = (state_q == EMPTY) | ~out_valid_q | out_ready;
  assign acc      = in_valid & in_ready;
  assign emit     = out_valid_q & out_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= EMPTY;
      hold_q      <= 8'h00;
      dataout_q   <= 16'h0000;
      out_valid_q <= 1'b0;
      pair_err_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      hold_q      <= hold_d;
      dataout_q   <= dataout_d;
      out_valid_q <= out_valid_d;
      pair_err_q  <= pair_err_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    hold_d      = hold_q;
    dataout_d   = dataout_q;
    out_valid_d = out_valid_q & ~emit;
    pair_err_d  = 1'b0;
    if (acc) begin
      case (state_q)
        EMPTY: begin
          hold_d  = datain;
          state_d = HALF;
        end
        HALF: begin
          if (align) begin
            // The held byte belongs to a broken pair; restart from this byte.
            hold_d     = datain;
            pair_err_d = 1'b1;
          end else begin
            dataout_d   = (MSB_FIRST != 0) ? {hold_q, datain} : {datain, hold_q};
            out_valid_d = 1'b1;
            state_d     = EMPTY;
          end
        end
        default: state_d = EMPTY;
      endcase
    end
  end

  assign dataout   = dataout_q;
  assign out_valid = out_valid_q;
  assign pair_err  = pair_err_q;
  assign phase     = (state_q == HALF);

endmodule

// File: tb/tb_data_assembler_8to16.sv
// Bench for data_assembler_8to16: both byte orders driven side by side, a
// byte-list reference model feeding per-DUT expected-word queues.
module tb_data_assembler_8to16;

  logic        clk;
  logic        rst;
  logic [7:0]  datain;
  logic        in_valid;
  logic        align;
  logic        out_ready;
  logic        in_ready1, out_valid1, pair_err1, phase1;
  logic        in_ready0, out_valid0, pair_err0, phase0;
  logic [15:0] dataout1, dataout0;

  int n_chk  = 0;
  int n_pass = 0;
  int n_fail = 0;
  logic chk_en  = 1'b0;
  logic rand_or = 1'b0;

  // Reference model state: bytes of the word under construction, and
  // whether the output register is expected to hold an unconsumed word.
  logic [7:0]  partial[$];
  logic [15:0] exp_q1[$];
  logic [15:0] exp_q0[$];
  logic        m_pending  = 1'b0;
  logic        m_pair_err = 1'b0;
  logic        m_in_ready;
  logic        m_acc, m_emit, m_complete;

  data_assembler_8to16 #(.MSB_FIRST(1)) u_msb (
    .clk(clk), .rst(rst), .datain(datain), .in_valid(in_valid), .align(align),
    .in_ready(in_ready1), .dataout(dataout1), .out_valid(out_valid1),
    .out_ready(out_ready), .pair_err(pair_err1), .phase(phase1)
  );

  data_assembler_8to16 #(.MSB_FIRST(0)) u_lsb (
    .clk(clk), .rst(rst), .datain(datain), .in_valid(in_valid), .align(align),
    .in_ready(in_ready0), .dataout(dataout0), .out_valid(out_valid0),
    .out_ready(out_ready), .pair_err(pair_err0), .phase(phase0)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end else begin
      n_pass++;
    end
  endtask

  // ---------------- reference model ----------------
  always @(negedge clk) begin
    m_in_ready = (partial.size() == 0) || !m_pending || out_ready;
    if (chk_en && !rst) begin
      chk("in_ready_msb", in_ready1, m_in_ready);
      chk("in_ready_lsb", in_ready0, m_in_ready);
      chk("out_valid_msb", out_valid1, m_pending);
      chk("out_valid_lsb", out_valid0, m_pending);
      chk("pair_err_msb", pair_err1, m_pair_err);
      chk("pair_err_lsb", pair_err0, m_pair_err);
      chk("phase_msb", phase1, partial.size() == 1);
      chk("phase_lsb", phase0, partial.size() == 1);
    end
    if (rst) begin
      partial.delete();
      exp_q1.delete();
      exp_q0.delete();
      m_pending  = 1'b0;
      m_pair_err = 1'b0;
    end else begin
      m_acc      = in_valid && m_in_ready;
      m_emit     = m_pending && out_ready;
      m_complete = 1'b0;
      m_pair_err = 1'b0;
      if (m_acc) begin
        if (align && partial.size() == 1) begin
          partial.delete();
          m_pair_err = 1'b1;
        end
        partial.push_back(datain);
        if (partial.size() == 2) begin
          exp_q1.push_back({partial[0], partial[1]});
          exp_q0.push_back({partial[1], partial[0]});
          partial.delete();
          m_complete = 1'b1;
        end
      end
      if (m_complete)  m_pending = 1'b1;
      else if (m_emit) m_pending = 1'b0;
    end
  end

  // ---------------- scoreboard monitors ----------------
  always @(negedge clk) begin
    if (chk_en && !rst && out_valid1) begin
      if (exp_q1.size() == 0) begin
        chk("word_msb_unexpected", dataout1, 32'hFFFF_FFFF);
      end else begin
        chk("word_msb", dataout1, exp_q1[0]);
        if (out_ready) void'(exp_q1.pop_front());
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en && !rst && out_valid0) begin
      if (exp_q0.size() == 0) begin
        chk("word_lsb_unexpected", dataout0, 32'hFFFF_FFFF);
      end else begin
        chk("word_lsb", dataout0, exp_q0[0]);
        if (out_ready) void'(exp_q0.pop_front());
      end
    end
  end

  always @(posedge clk) begin
    if (rand_or) begin
      #1;
      out_ready = ($urandom_range(0, 3) != 0);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic send_byte(input logic [7:0] b, input logic al);
    int t;
    in_valid = 1'b1;
    datain   = b;
    align    = al;
    t = 0;
    @(negedge clk);
    while (!in_ready1 && t < 100) begin
      @(negedge clk);
      t++;
    end
    chk("accept_wait_timeout", (t >= 100), 1'b0);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    align    = 1'b0;
    datain   = 8'($urandom);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1;
    repeat (n) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst = 1'b1; datain = 8'h00; in_valid = 1'b0; align = 1'b0; out_ready = 1'b0;
    @(posedge clk); #1;
    do_reset(3);
    chk_en = 1'b1;
    chk("reset_dataout_msb", dataout1, 16'h0000);
    chk("reset_dataout_lsb", dataout0, 16'h0000);

    // Streaming at full rate, both byte orders
    out_ready = 1'b1;
    send_byte(8'h12, 1'b0); send_byte(8'h34, 1'b0);
    send_byte(8'h56, 1'b0); send_byte(8'h78, 1'b0);
    idle(3);

    // Backpressure: the fourth byte must wait for the consumer
    out_ready = 1'b0;
    send_byte(8'hAA, 1'b0); send_byte(8'hBB, 1'b0); send_byte(8'hCC, 1'b0);
    fork
      send_byte(8'hDD, 1'b0);
      begin
        repeat (4) @(posedge clk);
        #1 out_ready = 1'b1;
      end
    join
    idle(3);

    // Realign discards the held byte
    send_byte(8'h11, 1'b0); send_byte(8'h22, 1'b1); send_byte(8'h33, 1'b0);
    idle(3);

    // Reset with a byte held and a word pending
    out_ready = 1'b0;
    send_byte(8'hE1, 1'b0); send_byte(8'hE2, 1'b0); send_byte(8'h5A, 1'b0);
    do_reset(1);
    chk("midreset_dataout_msb", dataout1, 16'h0000);
    chk("midreset_dataout_lsb", dataout0, 16'h0000);
    out_ready = 1'b1;
    send_byte(8'h01, 1'b0); send_byte(8'h02, 1'b0);
    idle(3);

    // Emit of the pending word coincides with completion of the next
    out_ready = 1'b0;
    send_byte(8'h01, 1'b0); send_byte(8'h02, 1'b0); send_byte(8'h03, 1'b0);
    idle(2);
    out_ready = 1'b1;
    send_byte(8'h04, 1'b0);
    idle(3);

    // Randomized traffic with gaps, align marks and consumer stalls
    rand_or = 1'b1;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 4) == 0) idle($urandom_range(1, 3));
      send_byte(8'($urandom), ($urandom_range(0, 7) == 0));
    end
    rand_or = 1'b0;
    @(posedge clk); #1;
    out_ready = 1'b1;
    idle(6);
    chk("drain_msb_empty", exp_q1.size(), 0);
    chk("drain_lsb_empty", exp_q0.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
